// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SLL / SRL / SRA / ROL with a valid/ready handshake
// at both ends and a sideband tag. The log2(DATA_W) mux levels are distributed
// over PIPE_STAGES register stages. Level k lives in stage k*PIPE_STAGES/SHAMT_W.
module pipelined_barrel_shifter #(
  parameter  int DATA_W      = 32,
  parameter  int PIPE_STAGES = 2,
  parameter  int TAG_W       = 4,
  localparam int SHAMT_W     = $clog2(DATA_W)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_in_ready,
  input  logic [DATA_W-1:0]  i_op_a,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [1:0]         i_mode,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_W-1:0]  o_result,
  output logic [TAG_W-1:0]   o_tag,
  output logic               o_busy
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  // One mux level: shift v by amt with the fill rule of the mode.
  // The SRA fill uses the sign captured at input, not the partial data MSB.
  function automatic logic [DATA_W-1:0] lvl_shift(input logic [DATA_W-1:0] v,
                                                  input int amt,
                                                  input logic [1:0] md,
                                                  input logic sg);
    logic [DATA_W-1:0] ones;
    logic [DATA_W-1:0] r;
    ones = '1;
    case (md)
      MODE_SLL: r = v << amt;
      MODE_SRL: r = v >> amt;
      MODE_SRA: r = (v >> amt) | (sg ? ~(ones >> amt) : '0);
      default:  r = (v << amt) | (v >> (DATA_W - amt));
    endcase
    return r;
  endfunction

  // Per-stage outputs collected so neighbours and the port logic can see them.
  logic [PIPE_STAGES-1:0][DATA_W-1:0] stg_data;
  logic [PIPE_STAGES-1:0][TAG_W-1:0]  stg_tag;
  logic [PIPE_STAGES-1:0]             stg_vld;
  logic [PIPE_STAGES-1:0]             rdy;

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_st
    // Levels [LO, HI) are handled in this stage.
    localparam int LO = (s * SHAMT_W + PIPE_STAGES - 1) / PIPE_STAGES;
    localparam int HI = ((s + 1) * SHAMT_W + PIPE_STAGES - 1) / PIPE_STAGES;

    logic [DATA_W-1:0]  d_in;
    logic [TAG_W-1:0]   t_in;
    logic               v_in;
    logic [SHAMT_W-1:LO] sh_in;  // only the shamt bits not yet consumed
    logic [1:0]         md_in;
    logic               sg_in;
    logic [DATA_W-1:0]  data_d;
    logic [DATA_W-1:0]  data_q;
    logic [TAG_W-1:0]   tag_q;
    logic               vld_q;
    logic               ld;

    if (s == 0) begin : g_src
      assign d_in  = i_op_a;
      assign t_in  = i_tag;
      assign v_in  = i_valid;
      assign sh_in = i_shamt;
      assign md_in = i_mode;
      assign sg_in = i_op_a[DATA_W-1];
    end else begin : g_src
      assign d_in  = stg_data[s-1];
      assign t_in  = stg_tag[s-1];
      assign v_in  = stg_vld[s-1];
      assign sh_in = g_st[s-1].g_ctl.sh_q;
      assign md_in = g_st[s-1].g_ctl.md_q;
      assign sg_in = g_st[s-1].g_ctl.sg_q;
    end

    // A stage can take new data if any stage at or after it is empty, or the
    // consumer is ready; equivalent to the chained !valid || ready_next form.
    assign rdy[s] = i_ready | ~(&stg_vld[PIPE_STAGES-1:s]);
    assign ld     = rdy[s] & v_in & ~i_flush;

    // Apply this stage's shift levels to the incoming partial result.
    always_comb begin
      data_d = d_in;
      for (int k = LO; k < HI; k++)
        if (sh_in[k]) data_d = lvl_shift(data_d, 1 << k, md_in, sg_in);
    end

    // Stage register: flush beats advance; data/tag only move with real work.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        vld_q  <= 1'b0;
        data_q <= '0;
        tag_q  <= '0;
      end else begin
        if (i_flush)     vld_q <= 1'b0;
        else if (rdy[s]) vld_q <= v_in;
        if (ld) begin
          data_q <= data_d;
          tag_q  <= t_in;
        end
      end
    end

    // Control sideband exists only where a later stage still needs it.
    if (s < PIPE_STAGES - 1) begin : g_ctl
      logic [SHAMT_W-1:HI] sh_q;
      logic [1:0]          md_q;
      logic                sg_q;

      // Remaining shamt bits, mode and captured sign travel with the data.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          sh_q <= '0;
          md_q <= '0;
          sg_q <= 1'b0;
        end else if (ld) begin
          sh_q <= sh_in[SHAMT_W-1:HI];
          md_q <= md_in;
          sg_q <= sg_in;
        end
      end
    end

    assign stg_data[s] = data_q;
    assign stg_tag[s]  = tag_q;
    assign stg_vld[s]  = vld_q;
  end

  assign o_in_ready = rdy[0];
  assign o_valid    = stg_vld[PIPE_STAGES-1];
  assign o_result   = stg_data[PIPE_STAGES-1];
  assign o_tag      = stg_tag[PIPE_STAGES-1];
  assign o_busy     = |stg_vld;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed checks on a 2-stage shifter plus queue-model regressions on
// 1-, 3- and 5-stage instances with random downstream readiness.
module tb_pipelined_barrel_shifter;

  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROL = 2'b11;

  logic        clk = 1'b0;
  logic        rst, flush, valid, in_ready, ready, o_valid, busy;
  logic [31:0] op_a, result;
  logic [4:0]  shamt;
  logic [1:0]  mode;
  logic [3:0]  tag, o_tag;
  logic        rnd_go = 1'b0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.DATA_W(32), .PIPE_STAGES(2), .TAG_W(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid(valid),
    .o_in_ready(in_ready), .i_op_a(op_a), .i_shamt(shamt), .i_mode(mode),
    .i_tag(tag), .o_valid(o_valid), .i_ready(ready), .o_result(result),
    .o_tag(o_tag), .o_busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] n,
                                            input logic [1:0] m);
    case (m)
      SLL:     return a << n;
      SRL:     return a >> n;
      SRA:     return $unsigned($signed(a) >>> n);
      default: return (n == 0) ? a : ((a << n) | (a >> (6'd32 - {1'b0, n})));
    endcase
  endfunction

  task automatic put(input logic v, input logic [31:0] a, input logic [4:0] s,
                     input logic [1:0] m, input logic [3:0] t);
    valid = v; op_a = a; shamt = s; mode = m; tag = t;
  endtask

  // Single op into an empty pipe with ready high: not valid after one edge,
  // valid with the right value and tag after two.
  task automatic one_op(input string nm, input logic [31:0] a, input logic [4:0] s,
                        input logic [1:0] m, input logic [3:0] t, input logic [31:0] exp);
    put(1'b1, a, s, m, t);
    @(negedge clk); put(1'b0, 0, 0, SLL, 0); #1;
    chk({nm, "_lat1"}, o_valid, 1'b0);
    @(negedge clk); #1;
    chk({nm, "_vld"}, o_valid, 1'b1);
    chk({nm, "_res"}, result, exp);
    chk({nm, "_tag"}, o_tag, t);
  endtask

  initial begin
    logic [31:0] gr[$];
    logic [3:0]  gt[$];
    logic [31:0] bp_exp [3];
    int ghost;
    bp_exp = '{32'h0000000C, 32'h0000000F, 32'h34567812};
    rst = 1'b0; flush = 1'b0; ready = 1'b1;
    put(1'b0, 0, 0, SLL, 0);
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_tag", o_tag, 4'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk); rst = 1'b0;

    // Modes, full-range amounts and sign fill
    one_op("sll31", 32'h00000001, 5'd31, SLL, 4'd5, 32'h80000000);
    one_op("rol1", 32'h80000001, 5'd1, ROL, 4'd6, 32'h00000003);
    one_op("sra_neg", 32'h80000000, 5'd4, SRA, 4'd7, 32'hF8000000);
    one_op("srl4", 32'h80000000, 5'd4, SRL, 4'd8, 32'h08000000);
    one_op("sra_pos", 32'h7FFFFFF0, 5'd4, SRA, 4'd9, 32'h07FFFFFF);
    one_op("rol31", 32'h00000003, 5'd31, ROL, 4'd10, 32'h80000001);

    // Zero amount in every mode, back to back, tags in order
    for (int j = 0; j < 6; j++) begin
      if (j >= 2) begin
        chk($sformatf("zero%0d_vld", j - 2), o_valid, 1'b1);
        chk($sformatf("zero%0d_res", j - 2), result, 32'hDEADBEEF);
        chk($sformatf("zero%0d_tag", j - 2), o_tag, 4'(j - 2));
      end
      if (j < 4) put(1'b1, 32'hDEADBEEF, 5'd0, 2'(j), 4'(j));
      else       put(1'b0, 0, 0, SLL, 0);
      @(negedge clk); #1;
    end

    // Backpressure: two accepted, third held off, output frozen
    ready = 1'b0;
    put(1'b1, 32'h00000003, 5'd2, SLL, 4'd1);
    @(negedge clk); #1;
    put(1'b1, 32'h000000F0, 5'd4, SRL, 4'd2);
    @(negedge clk); #1;
    put(1'b1, 32'h12345678, 5'd8, ROL, 4'd3);
    #1;
    chk("bp_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("bp_hold%0d_vld", i), o_valid, 1'b1);
      chk($sformatf("bp_hold%0d_res", i), result, 32'h0000000C);
      chk($sformatf("bp_hold%0d_tag", i), o_tag, 4'd1);
    end
    ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (o_valid) begin gr.push_back(result); gt.push_back(o_tag); end
      @(negedge clk); #1;
      put(1'b0, 0, 0, SLL, 0);
    end
    chk("bp_count", gr.size(), 3);
    for (int i = 0; i < 3 && i < gr.size(); i++) begin
      chk($sformatf("bp_out%0d_res", i), gr[i], bp_exp[i]);
      chk($sformatf("bp_out%0d_tag", i), gt[i], 4'(i + 1));
    end

    // Flush with two in flight and a new input on the same edge
    ready = 1'b0;
    put(1'b1, 32'h00000001, 5'd1, SLL, 4'd6);
    @(negedge clk); #1;
    put(1'b1, 32'h00000001, 5'd2, SLL, 4'd7);
    @(negedge clk); #1;
    ready = 1'b1; flush = 1'b1;
    put(1'b1, 32'h00000005, 5'd0, SLL, 4'd9);
    #1;
    chk("fl_in_ready", in_ready, 1'b1);
    chk("fl_busy_pre", busy, 1'b1);
    @(negedge clk); #1;
    flush = 1'b0;
    put(1'b0, 0, 0, SLL, 0);
    chk("fl_busy", busy, 1'b0);
    chk("fl_valid", o_valid, 1'b0);
    ghost = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (o_valid) ghost++;
    end
    chk("fl_ghost", ghost, 0);

    // Asynchronous reset between edges with two ops in flight
    ready = 1'b0;
    put(1'b1, 32'h000000FF, 5'd8, SLL, 4'hA);
    @(negedge clk); #1;
    put(1'b1, 32'h000000FF, 5'd8, SLL, 4'hB);
    @(negedge clk); #1;
    put(1'b0, 0, 0, SLL, 0);
    chk("ar_pre_vld", o_valid, 1'b1);
    chk("ar_pre_res", result, 32'h0000FF00);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", o_valid, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_result", result, 32'h0);
    chk("ar_tag", o_tag, 4'h0);
    chk("ar_in_ready", in_ready, 1'b1);
    @(negedge clk); rst = 1'b0; ready = 1'b1;
    one_op("ar_after", 32'h00000001, 5'd4, SLL, 4'd3, 32'h00000010);

    // Random regression on the other depths
    rnd_go = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) break;
      @(posedge clk);
    end
    chk("rnd_done", {g_rnd[2].done, g_rnd[1].done, g_rnd[0].done}, 3'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int P = (g == 0) ? 1 : (g == 1) ? 3 : 5;
    logic        v, rd, fl, ir, ov, bz, done;
    logic [31:0] a, res;
    logic [4:0]  sh;
    logic [1:0]  md;
    logic [3:0]  tg, otg;

    pipelined_barrel_shifter #(.DATA_W(32), .PIPE_STAGES(P), .TAG_W(4)) u_dut (
      .i_clk(clk), .i_reset(rst), .i_flush(fl), .i_valid(v), .o_in_ready(ir),
      .i_op_a(a), .i_shamt(sh), .i_mode(md), .i_tag(tg), .o_valid(ov),
      .i_ready(rd), .o_result(res), .o_tag(otg), .o_busy(bz)
    );

    initial begin
      logic [31:0] eq[$];
      logic [3:0]  tq[$];
      logic        took;
      int          n;
      v = 1'b0; rd = 1'b0; fl = 1'b0; done = 1'b0;
      a = '0; sh = '0; md = '0; tg = '0; took = 1'b0; n = 0;
      wait (rnd_go);
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        if (!v || took) begin
          if (c < 400 && $urandom_range(0, 3) != 0) begin
            v = 1'b1; a = $urandom; sh = 5'($urandom); md = 2'($urandom);
            tg = 4'(n); n++;
          end else v = 1'b0;
        end
        rd = ($urandom_range(0, 2) != 0);
        #1;
        took = v && ir;
        if (took) begin
          eq.push_back(ref_shift(a, sh, md));
          tq.push_back(tg);
        end
        if (ov && rd) begin
          if (eq.size() == 0) chk($sformatf("rnd%0d_extra", P), 1, 0);
          else begin
            chk($sformatf("rnd%0d_res", P), res, eq.pop_front());
            chk($sformatf("rnd%0d_tag", P), otg, tq.pop_front());
          end
        end
      end
      chk($sformatf("rnd%0d_left", P), eq.size(), 0);
      chk($sformatf("rnd%0d_busy", P), bz, 1'b0);
      done = 1'b1;
    end
  end

endmodule
